register_file: RTL and testbench
================================

REGISTER_FILE -- requirements
Module: register_file

Interface
REQ-001 SHALL have parameter DATA_W, default 32, register/data width in bits.
REQ-002 SHALL have parameter ADDR_W, default 5, register index width (2**ADDR_W registers).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port RegWrite  input  1  write enable for write port.
REQ-006 SHALL have port read_reg1  input  ADDR_W  read port 1 index (rs).
REQ-007 SHALL have port read_reg2  input  ADDR_W  read port 2 index (rt).
REQ-008 SHALL have port write_reg  input  ADDR_W  write port index (rd/rt).
REQ-009 SHALL have port write_data  input  DATA_W  write port data (ALU result or memory data).
REQ-010 SHALL have port read_data1  output  DATA_W  contents of read_reg1; drives ALU src0.
REQ-011 SHALL have port read_data2  output  DATA_W  contents of read_reg2; drives ALU src1 / store data.

Function
REQ-012 SHALL hold 2**ADDR_W registers of DATA_W bits each.
REQ-013 SHALL read combinationally: read_dataN reflects array[read_regN] in the same cycle, zero-cycle latency.
REQ-014 SHALL write write_data into array[write_reg] on the rising clk edge when RegWrite=1 and rst=0; new value visible on reads from the following cycle.
REQ-015 SHALL ignore writes to index 0; register 0 reads as 0 at all times.
REQ-016 SHALL return 0 on any read port addressing index 0, regardless of bypass or write activity.
REQ-017 SHALL leave all registers unchanged on an edge where RegWrite=0.
REQ-018 SHALL permit both read ports to address the same register and return identical data.
REQ-019 SHALL perform at most one write per cycle; no read port has side effects.
REQ-020 SHALL treat X/unused index bits as none: every ADDR_W-bit index is valid, no wrap or out-of-range case.

Reset
REQ-021 SHALL clear every register to 0 on a rising clk edge with rst=1.
REQ-022 SHALL give rst priority over RegWrite: a write presented in a reset cycle is discarded.
REQ-023 SHALL, after rst deasserts mid-operation, resume normal writes on the next edge with RegWrite=1; outputs read 0 until then.

Configuration
REQ-024 SHALL support macro REGFILE_BYPASS_EN.
REQ-025 With REGFILE_BYPASS_EN defined: when RegWrite=1, rst=0, write_reg!=0 and read_regN==write_reg, read_dataN SHALL return write_data combinationally in the same cycle (write-through).
REQ-026 Without REGFILE_BYPASS_EN: read_dataN SHALL return the stored (pre-write) value in that cycle; new value visible next cycle.
REQ-027 Bypass SHALL never apply during rst=1 or to index 0.

Structure
REQ-028 SHALL take DATA_W and ADDR_W defaults and constant REG_ZERO (index 0) from shared package mips_pkg, shared with the ALU and control.
REQ-029 SHALL implement each read port as one instance of sub-module regfile_read_port (index decode, zero-force, optional bypass mux), instantiated twice.
REQ-030 SHALL keep the storage array and write logic in register_file itself.

Verification
REQ-031 Reset: rst=1 one edge after arbitrary writes -> all 32 reads return 0x00000000.
REQ-032 Write/read: write 0x12345678 to r8, next cycle read_reg1=8, read_reg2=8 -> both 0x12345678.
REQ-033 Zero register: RegWrite=1, write_reg=0, write_data=0xFFFFFFFF -> read_reg1=0 returns 0 that cycle and after.
REQ-034 Simultaneous read/write: r9=0x1, write r9<=0xAAAA5555, read_reg2=9 same cycle -> 0xAAAA5555 with REGFILE_BYPASS_EN, 0x00000001 without; 0xAAAA5555 next cycle in both builds.
REQ-035 Reset priority: rst=1 with RegWrite=1, write_reg=5, write_data=0xDEADBEEF -> r5 reads 0 after the edge.
REQ-036 Disabled write: r3=0x7, RegWrite=0, write_reg=3, write_data=0x99 -> r3 still 0x7 next cycle.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS datapath constants used by the register file, ALU and control.
package mips_pkg;

  localparam int DATA_W_DEFAULT = 32;  // architectural register width
  localparam int ADDR_W_DEFAULT = 5;   // 32 architectural registers

  // Hard-wired zero register index ($zero)
  localparam int unsigned REG_ZERO = 0;

endpackage : mips_pkg

// File: rtl/regfile_read_port.sv
// One combinational register-file read port: index decode, $zero forcing and,
// when REGFILE_BYPASS_EN is defined, a write-through bypass mux.
module regfile_read_port
  import mips_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEFAULT,
  parameter int ADDR_W = ADDR_W_DEFAULT
) (
  input  logic [ADDR_W-1:0] rd_idx,
  input  logic [DATA_W-1:0] regs [2**ADDR_W],
  input  logic              wr_en,    // write really happens this edge (RegWrite && !rst)
  input  logic [ADDR_W-1:0] wr_idx,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] rd_data
);

`ifndef REGFILE_BYPASS_EN
  // Write-port inputs only feed the bypass mux; keep them visibly consumed.
  logic unused_bypass;
  assign unused_bypass = ^{wr_en, wr_idx, wr_data};
`endif

  // Select stored value, optionally forward the in-flight write, then force $zero.
  always_comb begin
    // NOTE: assigning a default first guarantees every path drives rd_data, so no latch.
    rd_data = regs[rd_idx];
`ifdef REGFILE_BYPASS_EN
    if (wr_en && (wr_idx == rd_idx)) begin
      rd_data = wr_data;
    end
`endif
    // Applied last so neither storage nor bypass can ever leak through index 0.
    if (rd_idx == ADDR_W'(REG_ZERO)) begin
      rd_data = '0;
    end
  end

endmodule : regfile_read_port

// File: rtl/register_file.sv
// MIPS-style register file: 2**ADDR_W x DATA_W, two combinational read ports,
// one synchronous write port, $zero hard-wired, synchronous active-high reset.
// Optional macro REGFILE_BYPASS_EN enables same-cycle write-through on reads.
module register_file
  import mips_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEFAULT,
  parameter int ADDR_W = ADDR_W_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              RegWrite,
  input  logic [ADDR_W-1:0] read_reg1,
  input  logic [ADDR_W-1:0] read_reg2,
  input  logic [ADDR_W-1:0] write_reg,
  input  logic [DATA_W-1:0] write_data,
  output logic [DATA_W-1:0] read_data1,
  output logic [DATA_W-1:0] read_data2
);

  localparam int NUM_REGS = 2**ADDR_W;

  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic [DATA_W-1:0] regs_d [NUM_REGS];
  logic              wr_en;

  // Reset wins over RegWrite; the same qualified enable gates the bypass.
  assign wr_en = RegWrite && !rst;

  // Next-state of the array: at most one register updated, $zero never written.
  always_comb begin
    regs_d = regs_q;
    if (wr_en && (write_reg != ADDR_W'(REG_ZERO))) begin
      regs_d[write_reg] = write_data;
    end
    regs_d[REG_ZERO] = '0;
  end

  // Storage update with synchronous clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the array is reset on purpose (software expects zeroed registers);
      // this keeps it in flops rather than an inferred RAM, which is acceptable here.
      for (int i = 0; i < NUM_REGS; i++) begin
        // NOTE: non-blocking assignment for all state so every flop samples pre-edge values.
        regs_q[i] <= '0;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  regfile_read_port #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_rd_port1 (
    .rd_idx  (read_reg1),
    .regs    (regs_q),
    .wr_en   (wr_en),
    .wr_idx  (write_reg),
    .wr_data (write_data),
    .rd_data (read_data1)
  );

  regfile_read_port #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_rd_port2 (
    .rd_idx  (read_reg2),
    .regs    (regs_q),
    .wr_en   (wr_en),
    .wr_idx  (write_reg),
    .wr_data (write_data),
    .rd_data (read_data2)
  );

endmodule : register_file

// File: tb/tb_register_file.sv
// Scoreboard bench for register_file: stimulus pushes expected read values,
// a monitor pops and compares them on the falling edge of the same cycle.
`timescale 1ns/1ps
module tb_register_file;

  localparam int DW = 32;
  localparam int AW = 5;

  logic          clk;
  logic          rst;
  logic          RegWrite;
  logic [AW-1:0] read_reg1;
  logic [AW-1:0] read_reg2;
  logic [AW-1:0] write_reg;
  logic [DW-1:0] write_data;
  logic [DW-1:0] read_data1;
  logic [DW-1:0] read_data2;

  register_file #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk        (clk),
    .rst        (rst),
    .RegWrite   (RegWrite),
    .read_reg1  (read_reg1),
    .read_reg2  (read_reg2),
    .write_reg  (write_reg),
    .write_data (write_data),
    .read_data1 (read_data1),
    .read_data2 (read_data2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string         name;
    int            port;   // 1 -> read_data1, 2 -> read_data2
    logic [DW-1:0] exp;
  } sb_item_t;

  sb_item_t sb[$];
  int total = 0;
  int bad   = 0;

`ifdef REGFILE_BYPASS_EN
  localparam logic BYPASS = 1'b1;
`else
  localparam logic BYPASS = 1'b0;
`endif

  task automatic check(input string name, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", name, got, exp);
    end
  endtask

  // Monitor: outputs are combinational, so compare mid-cycle on the falling edge.
  initial begin
    sb_item_t e;
    forever begin
      @(negedge clk);
      while (sb.size() > 0) begin
        e = sb.pop_front();
        check(e.name, (e.port == 2) ? read_data2 : read_data1, e.exp);
      end
    end
  end

  task automatic push(input string name, input int port, input logic [DW-1:0] exp);
    sb_item_t e;
    e.name = name;
    e.port = port;
    e.exp  = exp;
    sb.push_back(e);
  endtask

  task automatic drive(input logic we, input logic [AW-1:0] wr, input logic [DW-1:0] wd,
                       input logic [AW-1:0] r1, input logic [AW-1:0] r2);
    RegWrite   = we;
    write_reg  = wr;
    write_data = wd;
    read_reg1  = r1;
    read_reg2  = r2;
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int waited;
    rst = 1'b1;
    drive(1'b0, '0, '0, '0, '0);
    step();
    step();
    rst = 1'b0;

    // Fill r1..r31; each cycle read back the register written on the previous edge.
    for (int i = 1; i < 32; i++) begin
      drive(1'b1, AW'(i), 32'hA500_0000 | 32'(i), AW'(i - 1), 5'd0);
      push($sformatf("fill_rd_r%0d", i - 1), 1, (i == 1) ? 32'h0 : (32'hA500_0000 | 32'(i - 1)));
      step();
    end
    drive(1'b0, '0, '0, 5'd31, 5'd0);
    push("fill_rd_r31", 1, 32'hA500_001F);
    push("r0_after_fill", 2, 32'h0);
    step();

    // One reset edge, carrying a write that must be discarded.
    rst = 1'b1;
    drive(1'b1, 5'd5, 32'hDEAD_BEEF, 5'd0, 5'd0);
    step();
    rst = 1'b0;
    for (int i = 0; i < 16; i++) begin
      drive(1'b0, '0, '0, AW'(2 * i), AW'(2 * i + 1));
      push($sformatf("post_rst_r%0d", 2 * i), 1, 32'h0);
      push($sformatf("post_rst_r%0d", 2 * i + 1), 2, 32'h0);
      step();
    end

    // Write r8, read on both ports next cycle.
    drive(1'b1, 5'd8, 32'h1234_5678, 5'd0, 5'd0);
    step();
    drive(1'b0, '0, '0, 5'd8, 5'd8);
    push("r8_port1", 1, 32'h1234_5678);
    push("r8_port2", 2, 32'h1234_5678);
    step();

    // Write to $zero: reads 0 in that cycle and after.
    drive(1'b1, 5'd0, 32'hFFFF_FFFF, 5'd0, 5'd0);
    push("zero_same_cycle_p1", 1, 32'h0);
    push("zero_same_cycle_p2", 2, 32'h0);
    step();
    drive(1'b0, '0, '0, 5'd0, 5'd8);
    push("zero_next_cycle", 1, 32'h0);
    push("r8_intact", 2, 32'h1234_5678);
    step();

    // Simultaneous read/write of r9.
    drive(1'b1, 5'd9, 32'h0000_0001, 5'd0, 5'd0);
    step();
    drive(1'b1, 5'd9, 32'hAAAA_5555, 5'd8, 5'd9);
    push("r9_same_cycle", 2, BYPASS ? 32'hAAAA_5555 : 32'h0000_0001);
    push("r8_during_r9_write", 1, 32'h1234_5678);
    step();
    drive(1'b0, '0, '0, 5'd9, 5'd9);
    push("r9_next_cycle_p1", 1, 32'hAAAA_5555);
    push("r9_next_cycle_p2", 2, 32'hAAAA_5555);
    step();

    // Reset priority: no bypass and no store during rst.
    rst = 1'b1;
    drive(1'b1, 5'd5, 32'hDEAD_BEEF, 5'd5, 5'd9);
    push("r5_during_rst", 1, 32'h0);
    step();
    rst = 1'b0;
    drive(1'b0, '0, '0, 5'd5, 5'd9);
    push("r5_after_rst", 1, 32'h0);
    push("r9_cleared", 2, 32'h0);
    step();

    // Disabled write leaves r3 alone.
    drive(1'b1, 5'd3, 32'h0000_0007, 5'd0, 5'd0);
    step();
    drive(1'b0, 5'd3, 32'h0000_0099, 5'd3, 5'd0);
    push("r3_we0_same_cycle", 1, 32'h0000_0007);
    step();
    drive(1'b0, '0, '0, 5'd3, 5'd3);
    push("r3_we0_next_p1", 1, 32'h0000_0007);
    push("r3_we0_next_p2", 2, 32'h0000_0007);
    step();

    // Top index boundary.
    drive(1'b1, 5'd31, 32'hFFFF_FFFF, 5'd31, 5'd3);
    push("r31_same_cycle", 1, BYPASS ? 32'hFFFF_FFFF : 32'h0);
    push("r3_during_r31_write", 2, 32'h0000_0007);
    step();
    drive(1'b0, '0, '0, 5'd31, 5'd31);
    push("r31_p1", 1, 32'hFFFF_FFFF);
    push("r31_p2", 2, 32'hFFFF_FFFF);
    step();

    // Drain the scoreboard with a bounded wait.
    waited = 0;
    while (sb.size() > 0 && waited < 20) begin
      step();
      waited++;
    end
    if (sb.size() > 0) begin
      total++;
      bad++;
      $display("FAIL sb_drain: pending=%0d expected=0", sb.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_register_file
